// File: rtl/avalon_st_enforcer_pkg.sv
// Shared types and helpers for the Avalon-ST framing enforcer.
package avalon_st_enforcer_pack;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_MSG = 2'd1,
    DROP   = 2'd2
  } state_t;

  // Width of the empty field; a one-byte beat still carries a 1-bit empty.
  function automatic int log2up_func(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avalon_st_enforcer_if.sv
// Avalon-ST stream bundle with master (source) and slave (sink) views.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = avalon_st_enforcer_pack::log2up_func(DATA_WIDTH_IN_BYTES);

  // A beat transfers on a rising edge where valid & rdy. The master holds all
  // fields stable while valid & ~rdy; rdy may depend combinationally on state.
  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_enforcer_out_stage.sv
// Output register of the enforcer: loads a beat when told, drains on rdy.
module avalon_st_out_stage #(
  parameter type beat_t = logic
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  beat_t beat_in,
  input  logic  rdy,
  output logic  valid,
  output beat_t beat
);

  // The caller only asserts load when the stage is empty or draining this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      beat  <= beat_t'('0);
    end else if (load) begin
      valid <= 1'b1;
      beat  <= beat_in;
    end else if (rdy) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/avalon_st_enforcer.sv
// Packet-framing enforcer: repairs or drops beats so downstream always sees
// sop-first, single-eop packets no longer than MAX_MSG_LEN_IN_WORDS.
module avalon_st_enforcer
  import avalon_st_enforcer_pack::*;
#(
  parameter int DATA_WIDTH_IN_BYTES  = 16,
  parameter int MAX_MSG_LEN_IN_WORDS = 256,
  parameter int ERR_CNT_WIDTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  avalon_st_if.slave               untrusted_msg,
  avalon_st_if.master              enforced_msg,
  output logic                     missing_sop_error,
  output logic                     double_sop_error,
  output logic                     msg_too_long_error,
  output logic [ERR_CNT_WIDTH-1:0] missing_sop_cnt,
  output logic [ERR_CNT_WIDTH-1:0] double_sop_cnt,
  output logic [ERR_CNT_WIDTH-1:0] too_long_cnt,
  output state_t                   dbg_state
);

  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW = log2up_func(DATA_WIDTH_IN_BYTES);
  localparam int CW = $clog2(MAX_MSG_LEN_IN_WORDS + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  state_t        state, next_state;
  logic [CW-1:0] word_cnt, cnt_next;
  beat_t         hold_beat, load_beat, xfer_beat, out_beat;
  logic          hold_valid, out_valid;
  logic          in_fire, out_free, hold_xfer, hold_load, force_close;
  logic          missing_next, double_next, too_long_next;

  assign out_free          = ~out_valid | enforced_msg.rdy;
  assign untrusted_msg.rdy = ~hold_valid | out_free;
  assign in_fire           = untrusted_msg.valid & untrusted_msg.rdy;
  // A non-eop beat must wait for the next accepted beat to learn whether it ends the packet.
  assign hold_xfer         = hold_valid & out_free & (hold_beat.eop | in_fire);
  assign dbg_state         = state;

  always_comb begin
    next_state      = state;
    cnt_next        = word_cnt;
    hold_load       = 1'b0;
    force_close     = 1'b0;
    missing_next    = 1'b0;
    double_next     = 1'b0;
    too_long_next   = 1'b0;
    load_beat.data  = untrusted_msg.data;
    load_beat.sop   = untrusted_msg.sop;
    load_beat.eop   = untrusted_msg.eop;
    load_beat.empty = untrusted_msg.eop ? untrusted_msg.empty : '0;
    if (in_fire) begin
      case (state)
        IN_MSG: begin
          hold_load = 1'b1;
          if (untrusted_msg.sop) begin
            force_close = 1'b1;
            double_next = 1'b1;
            cnt_next    = CW'(1);
          end else begin
            cnt_next    = word_cnt + CW'(1);
          end
        end
        default: begin
          if (untrusted_msg.sop) begin
            hold_load = 1'b1;
            cnt_next  = CW'(1);
          end else if (state == IDLE) begin
            missing_next = 1'b1;
          end else if (untrusted_msg.eop) begin
            next_state = IDLE;
          end
        end
      endcase
      if (hold_load) begin
        if (load_beat.eop) begin
          next_state = IDLE;
        end else if (cnt_next == CW'(MAX_MSG_LEN_IN_WORDS)) begin
          load_beat.eop   = 1'b1;
          load_beat.empty = '0;
          too_long_next   = 1'b1;
          next_state      = DROP;
        end else begin
          next_state = IN_MSG;
        end
      end
    end
  end

  // A sop inside an open packet closes the held beat on its way out.
  always_comb begin
    xfer_beat = hold_beat;
    if (force_close) begin
      xfer_beat.eop   = 1'b1;
      xfer_beat.empty = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      hold_valid <= 1'b0;
      hold_beat  <= '0;
    end else begin
      state    <= next_state;
      word_cnt <= cnt_next;
      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_beat  <= load_beat;
      end else if (hold_xfer) begin
        hold_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      missing_sop_error  <= 1'b0;
      double_sop_error   <= 1'b0;
      msg_too_long_error <= 1'b0;
      missing_sop_cnt    <= '0;
      double_sop_cnt     <= '0;
      too_long_cnt       <= '0;
    end else begin
      missing_sop_error  <= missing_next;
      double_sop_error   <= double_next;
      msg_too_long_error <= too_long_next;
      if (missing_next && missing_sop_cnt != '1)
        missing_sop_cnt <= missing_sop_cnt + ERR_CNT_WIDTH'(1);
      if (double_next && double_sop_cnt != '1)
        double_sop_cnt <= double_sop_cnt + ERR_CNT_WIDTH'(1);
      if (too_long_next && too_long_cnt != '1)
        too_long_cnt <= too_long_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  avalon_st_out_stage #(.beat_t(beat_t)) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .load    (hold_xfer),
    .beat_in (xfer_beat),
    .rdy     (enforced_msg.rdy),
    .valid   (out_valid),
    .beat    (out_beat)
  );

  assign enforced_msg.valid = out_valid;
  assign enforced_msg.data  = out_beat.data;
  assign enforced_msg.sop   = out_beat.sop;
  assign enforced_msg.eop   = out_beat.eop;
  assign enforced_msg.empty = out_beat.empty;

endmodule
